// File: rtl/soc_system_pio_pkg.sv
// Shared definitions for the HPS lightweight-bridge PIO blocks:
// Altera-compatible register word addresses and the edge-capture selector.
package soc_system_pio_pkg;

  localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
  localparam logic [1:0] PIO_ADDR_DIR     = 2'd1;
  localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

  typedef enum logic [1:0] {
    RISING  = 2'd0,
    FALLING = 2'd1,
    ANY     = 2'd2
  } edge_type_e;

endpackage

// File: rtl/soc_system_pio_debounce.sv
// One-bit input conditioner: 2-FF synchroniser, stability counter and
// debounced level. The rise/fall pulses are high on the cycle before the edge
// that loads a new level, so a consumer registering them updates on the same
// edge as the level itself. They depend only on registers, so they never
// glitch with the asynchronous input.
module soc_system_pio_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter logic        RESET_VALUE     = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic in_bit,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_r;
  logic             sync2_r;
  logic             level_r;
  logic [CNT_W-1:0] cnt_r;
  logic             differ_s;
  logic             load_s;
  logic [CNT_W-1:0] cnt_next_s;

  // Counter clears on agreement or on acceptance, so it can never wrap
  always_comb begin
    differ_s   = (sync2_r != level_r);
    load_s     = differ_s && (cnt_r == CNT_LAST);
    cnt_next_s = {CNT_W{1'b0}};
    if (differ_s && !load_s) begin
      cnt_next_s = cnt_r + CNT_W'(1);
    end else begin
      cnt_next_s = {CNT_W{1'b0}};
    end
  end

  // Synchroniser, stability counter and debounced level register
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= RESET_VALUE;
      sync2_r <= RESET_VALUE;
      level_r <= RESET_VALUE;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      sync1_r <= in_bit;
      sync2_r <= sync1_r;
      level_r <= load_s ? sync2_r : level_r;
      cnt_r   <= cnt_next_s;
    end
  end

  assign level = level_r;
  assign rise  = load_s &  sync2_r;
  assign fall  = load_s & ~sync2_r;

endmodule

// File: rtl/soc_system_button_pio.sv
// Avalon-MM input PIO for push-buttons/switches: debounced data, interrupt
// mask and edge-capture registers with a level interrupt to the HPS.
module soc_system_button_pio
  import soc_system_pio_pkg::*;
#(
  parameter int unsigned      WIDTH           = 2,
  parameter int unsigned      DEBOUNCE_CYCLES = 50000,
  parameter edge_type_e       EDGE_TYPE       = FALLING,
  parameter logic [WIDTH-1:0] IN_RESET_VALUE  = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] level_s;
  logic [WIDTH-1:0] rise_s;
  logic [WIDTH-1:0] fall_s;
  logic [WIDTH-1:0] irq_mask_r;
  logic [WIDTH-1:0] edge_capture_r;
  logic [WIDTH-1:0] cap_set_s;
  logic [WIDTH-1:0] cap_clr_s;
  logic [WIDTH-1:0] cap_next_s;
  logic             wr_en_s;
  logic             mask_wr_s;
  logic             unused_wdata_s;

  // Upper write-data bits have no destination when WIDTH < 32
  assign unused_wdata_s = ^writedata;

  genvar g;
  for (g = 0; g < WIDTH; g++) begin : g_bit
    soc_system_pio_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VALUE     (IN_RESET_VALUE[g])
    ) u_debounce (
      .clk    (clk),
      .reset  (reset),
      .in_bit (in_port[g]),
      .level  (level_s[g]),
      .rise   (rise_s[g]),
      .fall   (fall_s[g])
    );
  end

  // Write decode and capture next-state; a set on the clearing edge wins
  always_comb begin
    wr_en_s   = chipselect && !write_n;
    mask_wr_s = wr_en_s && (address == PIO_ADDR_IRQMASK);
    cap_clr_s = {WIDTH{1'b0}};
    if (wr_en_s && (address == PIO_ADDR_EDGECAP)) begin
      cap_clr_s = writedata[WIDTH-1:0];
    end else begin
      cap_clr_s = {WIDTH{1'b0}};
    end
    case (EDGE_TYPE)
      RISING:  cap_set_s = rise_s;
      FALLING: cap_set_s = fall_s;
      ANY:     cap_set_s = rise_s | fall_s;
      default: cap_set_s = {WIDTH{1'b0}};
    endcase
    cap_next_s = (edge_capture_r & ~cap_clr_s) | cap_set_s;
  end

  // Software-visible mask and edge-capture registers
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_mask_r     <= {WIDTH{1'b0}};
      edge_capture_r <= {WIDTH{1'b0}};
    end else begin
      irq_mask_r     <= mask_wr_s ? writedata[WIDTH-1:0] : irq_mask_r;
      edge_capture_r <= cap_next_s;
    end
  end

  // Zero-wait-state read mux, zero-extended to the bus width
  always_comb begin
    readdata = 32'd0;
    case (address)
      PIO_ADDR_DATA:    readdata[WIDTH-1:0] = level_s;
      PIO_ADDR_DIR:     readdata = 32'd0;
      PIO_ADDR_IRQMASK: readdata[WIDTH-1:0] = irq_mask_r;
      PIO_ADDR_EDGECAP: readdata[WIDTH-1:0] = edge_capture_r;
      default:          readdata = 32'd0;
    endcase
  end

  assign irq = |(edge_capture_r & irq_mask_r);

endmodule

// File: doc/soc_system_button_pio.md
# soc_system_button_pio

Avalon-MM input PIO: the read-side counterpart of the LED output PIO on the HPS lightweight bridge. It samples external push-buttons or switches, synchronises and debounces each bit, and exposes the debounced level, a per-bit edge-capture register and a maskable interrupt to software. The register map is compatible with the standard Altera PIO: data at 0, interrupt mask at 2, edge capture at 3.

## Interface
- WIDTH, 2: number of input bits, 1..32.
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles required to accept a new level, ≥1 (1 ms at 50 MHz).
- EDGE_TYPE, FALLING: RISING, FALLING or ANY; the edge that sets a capture bit.
- IN_RESET_VALUE, all ones: reset value of the synchroniser and debounced level (buttons are active-low).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- address  in  2  word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- in_port  in  WIDTH  asynchronous external inputs
- readdata  out  32  read data, zero wait states
- irq  out  1  level interrupt to the HPS

## Operation
- Per bit, a 2-FF synchroniser feeds a stability counter. The counter clears whenever the synchronised value equals the debounced value. Otherwise it increments. When it reaches DEBOUNCE_CYCLES−1 while still differing, the next edge loads the debounced bit and clears the counter.
- A glitch shorter than DEBOUNCE_CYCLES cycles never changes the debounced level. Any return to the old value restarts the count.
- Counter width is $clog2(DEBOUNCE_CYCLES+1), and the counter never wraps.
- Edge capture bit i sets on the same edge on which debounced bit i changes in the EDGE_TYPE direction. It stays set until cleared.
- Writes are accepted when chipselect && !write_n:
  - addr 2: irq_mask <= writedata[WIDTH-1:0].
  - addr 3: each bit written 1 clears the matching capture bit; bits written 0 are unaffected.
  - addr 0 and addr 1: ignored.
- Reads (combinational, zero-extended to 32 bits):
  - addr 0: debounced level.
  - addr 1: 0.
  - addr 2: irq_mask.
  - addr 3: edge_capture.
- Set and clear of the same capture bit on the same edge: set wins, so no event is lost.
- irq = |(edge_capture & irq_mask), derived combinationally from registers and free of glitches from in_port.
- Reset values:
  - sync FFs and debounced level = IN_RESET_VALUE.
  - counters, irq_mask, edge_capture = 0.
  - irq = 0.
  - readdata follows the reset register values.
- Reset asserted mid-debounce discards the pending transition. It creates no capture event, even if the restored IN_RESET_VALUE differs from the prior level.

## Timing
- in_port change sampled at edge 0 → synchronised value valid after edge 2 → debounced level and capture bit update at edge DEBOUNCE_CYCLES+2 (input held stable throughout).
- irq asserts in the same cycle the capture bit (if masked in) becomes visible, i.e. after edge DEBOUNCE_CYCLES+2.
- A mask write is effective for irq on the cycle after the write edge. A capture clear deasserts irq on the cycle after the write edge, unless a new event sets it on that same edge.
- readdata is valid in the same cycle as address/chipselect (readLatency 0). A read has no side effects.

## Structure
- Package soc_system_pio_pkg holds:
  - address constants PIO_ADDR_DATA=0, PIO_ADDR_DIR=1, PIO_ADDR_IRQMASK=2, PIO_ADDR_EDGECAP=3.
  - edge_type_e {RISING, FALLING, ANY}.
- Sub-module soc_system_pio_debounce is one bit wide and contains the synchroniser, counter and debounced FF. It outputs the level plus one-cycle rise/fall pulses. It is instantiated WIDTH times in a generate loop.
- The top level owns the mask, capture, read mux and irq.

## Test plan
- Reset with in_port=2'b11 → readdata@0 = 0x3, @2 = 0, @3 = 0, irq = 0. No capture after release of reset.
- DEBOUNCE_CYCLES=4, bit0 driven low for 3 cycles then high → data stays 0x3, capture stays 0.
- Bit0 driven low and held, mask=0x1 → data = 0x2 and capture = 0x1 at edge 6 after the change, with irq=1. Write 0x1 to addr 3 → capture = 0 and irq = 0 next cycle.
- Mask=0x0 and bit1 falls → capture = 0x2, irq stays 0. Write mask=0x2 → irq = 1 next cycle.
- Capture-clear write of 0x1 on the same edge as a new bit0 falling event → capture bit0 remains 1.
- EDGE_TYPE=ANY, bit1 pressed then released with 10-cycle gaps → capture bit1 sets on both edges. Writes to addr 0 and addr 1 do not change any readback.
